seven_seg_scanner: RTL

- Downstream display stage for the stopwatch.
- Consumes the four BCD time digits plus the is_adj / is_sel_sec status.
- Drives a 4-digit, common-anode, time-multiplexed 7-segment display.
- Handles digit scanning, anti-ghosting blanking, a frame-coherent digit snapshot, and blinking of the selected field while in adjust mode.

---
 rtl/seven_seg_scanner_if.sv | 26 ++
 rtl/seven_seg_scanner.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner_if.sv
// Display-side bundle for the stopwatch's 7-segment scanner.
// The master drives the BCD time digits and the adjust status, and it receives the
// active-low segment, decimal-point and anode drives.
interface seven_seg_scanner_if;
  logic [3:0] bcd_min_tens;
  logic [3:0] bcd_min_ones;
  logic [3:0] bcd_sec_tens;
  logic [3:0] bcd_sec_ones;
  logic       is_adj;
  logic       is_sel_sec;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  modport master (
    output bcd_min_tens, bcd_min_ones, bcd_sec_tens, bcd_sec_ones,
    output is_adj, is_sel_sec,
    input  seg, dp, an
  );

  modport slave (
    input  bcd_min_tens, bcd_min_ones, bcd_sec_tens, bcd_sec_ones,
    input  is_adj, is_sel_sec,
    output seg, dp, an
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Four-digit, common-anode, time-multiplexed 7-segment driver for the stopwatch.
// Each digit slot starts with GUARD cycles where every anode is off, to stop ghosting.
// All four digits are captured together at each frame boundary, so a frame never mixes
// two stopwatch states. In adjust mode the selected field blinks.
// The outputs are registered one clock after counter, index and phase state.
module seven_seg_scanner #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 25000000,
  parameter int unsigned GUARD       = 2
) (
  input  logic               clk_100mhz,
  input  logic               rst_n,
  seven_seg_scanner_if.slave disp
);

  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);
  localparam logic [RW-1:0] GUARD_CNT    = RW'(GUARD);

  typedef enum logic {
    PH_ON  = 1'b0,
    PH_OFF = 1'b1
  } phase_t;

  logic [RW-1:0]   refresh_cnt;
  logic [1:0]      idx;
  logic [3:0][3:0] snap;
  logic [BW-1:0]   blink_cnt;
  phase_t          phase;
  phase_t          phase_nxt;

  logic            refresh_tc;
  logic            blink_tc;
  logic            field_sel;
  logic            blank;
  logic [3:0]      an_d;
  logic [6:0]      seg_d;
  logic            dp_d;
  logic [3:0]      an_q;
  logic [6:0]      seg_q;
  logic            dp_q;

  assign refresh_tc = (refresh_cnt == REFRESH_LAST);
  assign blink_tc   = (blink_cnt == BLINK_LAST);

  // Active-low decode: {G,F,E,D,C,B,A}; non-BCD codes show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // Slot timer, digit index and frame-boundary snapshot of all four digits.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      idx         <= '0;
      snap        <= '0;
    end else if (refresh_tc) begin
      refresh_cnt <= '0;
      idx         <= idx + 2'd1;
      if (idx == 2'd3)
        snap <= {disp.bcd_min_tens, disp.bcd_min_ones, disp.bcd_sec_tens, disp.bcd_sec_ones};
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

  // Blink half-period counter; runs only while adjusting.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n)
      blink_cnt <= '0;
    else if (!disp.is_adj || blink_tc)
      blink_cnt <= '0;
    else
      blink_cnt <= blink_cnt + BW'(1);
  end

  // Blink phase register.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n)
      phase <= PH_ON;
    else
      phase <= phase_nxt;
  end

  // Blink phase next-state: forced on outside adjust mode, toggles each half-period.
  always_comb begin
    phase_nxt = phase;
    if (!disp.is_adj)
      phase_nxt = PH_ON;
    else if (blink_tc)
      phase_nxt = (phase == PH_ON) ? PH_OFF : PH_ON;
  end

  // Next display drive from current slot state, the snapshot and live status.
  always_comb begin
    an_d      = '1;
    seg_d     = '1;
    dp_d      = 1'b1;
    field_sel = disp.is_sel_sec ? (idx < 2'd2) : (idx >= 2'd2);
    blank     = (refresh_cnt < GUARD_CNT) ||
                (disp.is_adj && (phase == PH_OFF) && field_sel);
    if (!blank) begin
      an_d  = ~(4'b0001 << idx);
      seg_d = seg_decode(snap[idx]);
      dp_d  = (idx != 2'd2);
    end
  end

  // Registered display outputs; idle (all off) in reset.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= '1;
      seg_q <= '1;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign disp.an  = an_q;
  assign disp.seg = seg_q;
  assign disp.dp  = dp_q;

endmodule
